// File: rtl/riscv_defs.sv
// -----------------------------------------------------------------------------
// riscv_defs
// Shared definitions for the data-memory slice: default geometry, bus widths,
// the data-memory FSM state type and its state constants.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_defs;

   localparam int unsigned DMEM_DEPTH       = 1024;  // 32-bit words
   localparam int unsigned DMEM_WAIT_STATES = 1;     // extra cycles per access
   localparam int unsigned NB_ADDR          = 32;    // byte address width
   localparam int unsigned NB_WORD          = 32;    // data word width

   // Plain vector type with named constants keeps the encoding visible to
   // legacy tools and waveform viewers.
   typedef logic [1:0] dmem_state_t;

   localparam dmem_state_t S_INIT = 2'd0;  // clearing the array after reset
   localparam dmem_state_t S_IDLE = 2'd1;  // ready to accept a request
   localparam dmem_state_t S_WAIT = 2'd2;  // burning wait states
   localparam dmem_state_t S_RESP = 2'd3;  // response cycle

   // Width needed to hold 0..n-1, never less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : riscv_defs

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// CPU <-> data-memory bus.
//   dmem_address   : byte address            (cpu -> mem)
//   dmem_wr_data   : lane-formatted store data (cpu -> mem)
//   dmem_wr_enable : 1 = store, 0 = load     (cpu -> mem)
//   dmem_rd_data   : registered load data    (mem -> cpu)
// Modports: cpu (requester side), mem (memory side).
// -----------------------------------------------------------------------------
interface dmem_if
   import riscv_defs::*;
();

   logic [NB_ADDR-1:0] dmem_address;
   logic [NB_WORD-1:0] dmem_wr_data;
   logic               dmem_wr_enable;
   logic [NB_WORD-1:0] dmem_rd_data;

   modport cpu (
      output dmem_address,
      output dmem_wr_data,
      output dmem_wr_enable,
      input  dmem_rd_data
   );

   modport mem (
      input  dmem_address,
      input  dmem_wr_data,
      input  dmem_wr_enable,
      output dmem_rd_data
   );

endinterface : dmem_if

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// Single-port word RAM: synchronous write, synchronous registered read.
// The read register only updates on a read access, so it holds the last
// loaded word across stores and idle cycles.
//   i_clock   : clock
//   i_en      : access enable
//   i_we      : 1 = write, 0 = read (qualified by i_en)
//   i_idx     : word index
//   i_wr_data : write data
//   o_rd_data : last read word
// -----------------------------------------------------------------------------
module dmem_ram
   import riscv_defs::*;
#(
   parameter int unsigned DEPTH   = DMEM_DEPTH,
   parameter int unsigned IDX_W   = clog2_min1(DEPTH),
   parameter int unsigned WORD_W  = NB_WORD
)(
   input  logic              i_clock,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [WORD_W-1:0] i_wr_data,
   output logic [WORD_W-1:0] o_rd_data
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rd_data_q;

   // NOTE: the array has no reset branch so it maps onto block RAM; the
   // controller's clear sequence is what zeroes its contents.
   always_ff @(posedge i_clock) begin
      if (i_en) begin
         if (i_we) begin
            // NOTE: non-blocking assignment for every flop, so all state
            // updates see pre-edge values regardless of statement order.
            mem_q[i_idx] <= i_wr_data;
         end else begin
            rd_data_q <= mem_q[i_idx];
         end
      end
   end

   assign o_rd_data = rd_data_q;

endmodule : dmem_ram

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Word-addressed data memory with a request/ready/response handshake and a
// programmable number of wait states. After reset the array is cleared one
// word per cycle before the first request is accepted.
//   i_clock     : clock, rising edge
//   i_reset     : synchronous active-high reset
//   DMEM_IF     : dmem_if.mem -- address, store data, write enable, load data
//   i_req       : request qualifier (held by the requester until accepted)
//   o_ready     : high in the idle state; a request is accepted on that edge
//   o_rsp_valid : one-cycle completion pulse
//   o_error     : sticky out-of-range access flag, cleared by reset only
// -----------------------------------------------------------------------------
module data_memory
   import riscv_defs::*;
#(
   parameter int unsigned DEPTH       = DMEM_DEPTH,
   parameter int unsigned WAIT_STATES = DMEM_WAIT_STATES
)(
   input  logic   i_clock,
   input  logic   i_reset,
   dmem_if.mem    DMEM_IF,
   input  logic   i_req,
   output logic   o_ready,
   output logic   o_rsp_valid,
   output logic   o_error
);

   localparam int unsigned IDX_W     = clog2_min1(DEPTH);
   localparam int unsigned WS_W      = clog2_min1(WAIT_STATES);
   localparam int unsigned WAIT_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
   // One bit wider than the address so DEPTH*4 never wraps.
   localparam logic [NB_ADDR:0] ADDR_LIMIT = (NB_ADDR + 1)'(64'(DEPTH) * 64'd4);

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   dmem_state_t        state_q,    state_d;
   logic [IDX_W-1:0]   clr_idx_q,  clr_idx_d;
   logic [WS_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic [NB_ADDR-1:0] addr_q,     addr_d;
   logic [NB_WORD-1:0] wr_data_q,  wr_data_d;
   logic               wr_en_q,    wr_en_d;
   logic               error_q,    error_d;
   // Forces the load-data output to zero: set by reset and by an
   // out-of-range load, cleared by an in-range load.
   logic               rd_zero_q,  rd_zero_d;

   // --------------------------------------------------------------------------
   // Access operands: straight from the bus on the acceptance edge (only
   // reachable with zero wait states), otherwise from the captured copy.
   // --------------------------------------------------------------------------
   logic [NB_ADDR-1:0] acc_addr;
   logic [NB_WORD-1:0] acc_wr_data;
   logic               acc_wr_en;
   logic               acc_oor;
   logic [IDX_W-1:0]   acc_idx;

   always_comb begin
      if (state_q == S_IDLE) begin
         acc_addr    = DMEM_IF.dmem_address;
         acc_wr_data = DMEM_IF.dmem_wr_data;
         acc_wr_en   = DMEM_IF.dmem_wr_enable;
      end else begin
         acc_addr    = addr_q;
         acc_wr_data = wr_data_q;
         acc_wr_en   = wr_en_q;
      end
      acc_oor = ({1'b0, acc_addr} >= ADDR_LIMIT);
      acc_idx = acc_addr[IDX_W+1:2];
   end

   // --------------------------------------------------------------------------
   // FSM and RAM port control
   // --------------------------------------------------------------------------
   logic               access;      // this edge performs the captured access
   logic               ram_en;
   logic               ram_we;
   logic [IDX_W-1:0]   ram_idx;
   logic [NB_WORD-1:0] ram_wr_data;
   logic [NB_WORD-1:0] ram_rd_data;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d     = state_q;
      clr_idx_d   = clr_idx_q;
      wait_cnt_d  = wait_cnt_q;
      addr_d      = addr_q;
      wr_data_d   = wr_data_q;
      wr_en_d     = wr_en_q;
      error_d     = error_q;
      rd_zero_d   = rd_zero_q;
      access      = 1'b0;
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      ram_idx     = acc_idx;
      ram_wr_data = acc_wr_data;

      case (state_q)
         S_INIT: begin
            ram_en      = 1'b1;
            ram_we      = 1'b1;
            ram_idx     = clr_idx_q;
            ram_wr_data = '0;
            if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
               clr_idx_d = '0;
               state_d   = S_IDLE;
            end else begin
               clr_idx_d = clr_idx_q + IDX_W'(1);
            end
         end

         S_IDLE: begin
            if (i_req) begin
               addr_d    = DMEM_IF.dmem_address;
               wr_data_d = DMEM_IF.dmem_wr_data;
               wr_en_d   = DMEM_IF.dmem_wr_enable;
               if (WAIT_STATES == 0) begin
                  access  = 1'b1;
                  state_d = S_RESP;
               end else begin
                  wait_cnt_d = WS_W'(WAIT_LOAD);
                  state_d    = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            if (wait_cnt_q == '0) begin
               access  = 1'b1;
               state_d = S_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q - WS_W'(1);
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_INIT;
         end
      endcase

      // The access itself happens on the edge that enters S_RESP. An
      // out-of-range access never touches the array.
      if (access) begin
         ram_en = !acc_oor;
         ram_we = acc_wr_en;
         if (acc_oor) begin
            error_d = 1'b1;
         end
         if (!acc_wr_en) begin
            rd_zero_d = acc_oor;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= S_INIT;
         clr_idx_q  <= '0;
         wait_cnt_q <= '0;
         error_q    <= 1'b0;
         rd_zero_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         clr_idx_q  <= clr_idx_d;
         wait_cnt_q <= wait_cnt_d;
         error_q    <= error_d;
         rd_zero_q  <= rd_zero_d;
      end
   end

   // Captured request operands need no reset: they are only consumed after a
   // fresh acceptance has loaded them.
   always_ff @(posedge i_clock) begin
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
   end

   // --------------------------------------------------------------------------
   // Storage. Reset blocks the RAM port so an in-flight access is dropped.
   // --------------------------------------------------------------------------
   dmem_ram #(
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .WORD_W (NB_WORD)
   ) u_ram (
      .i_clock   (i_clock),
      .i_en      (ram_en && !i_reset),
      .i_we      (ram_we),
      .i_idx     (ram_idx),
      .i_wr_data (ram_wr_data),
      .o_rd_data (ram_rd_data)
   );

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign DMEM_IF.dmem_rd_data = rd_zero_q ? '0 : ram_rd_data;
   assign o_ready              = (state_q == S_IDLE);
   assign o_rsp_valid          = (state_q == S_RESP);
   assign o_error              = error_q;

endmodule : data_memory
